sub_regfile: RTL
================

# sub_regfile

Parametrised operand register bank with a built-in subtract/modulo engine. It generalises the single hand-muxed accumulator of the subtract datapath into NREGS registers of WIDTH bits. Registers are loaded from an external input, copied from one another, or updated with a subtract result. A start/done command handshake drives an iterative modulo (repeated-subtract) operation. It sits between the sequencing controller and the subtract/compare datapath.

## Interface
- WIDTH, 16, data width of every register (≥2)
- NREGS, 4, number of registers (≥2); ADDR_W = $clog2(NREGS)

- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  bank can accept a command (high in IDLE)
- cmd_op  in  2  0 LOAD, 1 COPY, 2 SUB, 3 MOD
- cmd_dst  in  ADDR_W  destination register
- cmd_src  in  ADDR_W  source register (COPY/SUB/MOD)
- cmd_data  in  WIDTH  load value (LOAD)
- rd_addr  in  ADDR_W  read port address
- rd_data  out  WIDTH  combinational read of R[rd_addr]; 0 if out of range
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse, coincident with done, on an illegal command
- borrow  out  1  sticky result of the last SUB (R[dst] < R[src] before the subtract)

## Operation
- Accept = cmd_valid && cmd_ready, sampled at the rising CLK edge.
- States: IDLE, MOD_LOOP.
- LOAD: R[dst] <= cmd_data at the accept edge.
- COPY: R[dst] <= R[src] at the accept edge.
- SUB: R[dst] <= (R[dst] − R[src]) mod 2^WIDTH at the accept edge. borrow <= (R[dst] < R[src]). dst==src gives 0 and borrow 0.
- Single-cycle ops leave the FSM in IDLE, so back-to-back commands are accepted every cycle.
- MOD: latch dst/src at the accept edge and go to MOD_LOOP.
  - Each MOD_LOOP cycle: if R[dst] ≥ R[src], then R[dst] <= R[dst] − R[src]. Otherwise go to IDLE.
  - Final value is R[dst] mod R[src]. R[src] is never written during MOD.
- MOD with R[src]==0 at accept: no write, stays IDLE, err pulse.
- MOD with dst==src and a nonzero value: result 0.
- Illegal command → no register write, done+err pulse. Illegal means dst or src ≥ NREGS, or MOD when compiled out.
- Comparisons are unsigned. Subtraction is WIDTH-bit wraparound.

## Timing
- Reset values: all R = 0, FSM = IDLE, done = 0, err = 0, borrow = 0. cmd_ready is 1 out of reset.
- done and err are registered. They are high in the cycle after the completing edge.
  - LOAD/COPY/SUB/illegal: the cycle after accept.
  - MOD: the cycle after the edge that leaves MOD_LOOP.
- MOD latency: accept edge, then q subtract edges (q = floor(a/b)), then one terminating compare edge. done follows in the next cycle.
- cmd_ready = (state == IDLE). It is low for the whole MOD_LOOP and high again in the done cycle, so a new command may be accepted while done is high.
- rd_data reflects a write from the cycle after the write edge. There is no bypass.
- Reset asserted mid-MOD aborts immediately: registers clear, no done pulse.

## Configuration
- SUB_REGFILE_MOD_EN defined: MOD opcode and the MOD_LOOP state are implemented as above.
- Not defined: no MOD_LOOP logic. cmd_op 3 is illegal: it is accepted, makes no write, and gives a done+err pulse the next cycle. cmd_ready is then constantly 1 outside reset.

## Structure
- Package sub_regfile_pkg holds:
  - the opcode typedef enum (OP_LOAD, OP_COPY, OP_SUB, OP_MOD);
  - the FSM state typedef;
  - the default WIDTH/NREGS constants.
- One sub-module, sub_regfile_alu. It is combinational: inputs a, b; outputs diff = a−b and ge = (a ≥ b). It is shared by SUB and MOD.
- The register array, write-select mux and FSM live in the top.

## Test plan
- Reset, then LOAD R0=17 and R1=5, then MOD dst0 src1. Required:
  - cmd_ready low for 4 cycles;
  - R0 steps 12, 7, 2;
  - done high in the cycle after the 4th MOD edge;
  - R0 = 2, R1 = 5.
- LOAD R2=3, then SUB dst2 src1 with R1=5. Required: R2 = 0xFFFE, borrow = 1, done one cycle after accept, err 0.
- MOD with R[src]=0: R[dst] unchanged, done+err pulse next cycle, cmd_ready never drops.
- Back-to-back LOAD R3=0xAAAA then COPY R0<=R3 on consecutive cycles. Required: R0 = 0xAAAA and two consecutive done pulses.
- Reset asserted during a MOD of 0xFFFF by 1. Required: all registers 0, no done, cmd_ready 1 after reset release.
- NREGS=3 build, LOAD dst=3. Required: no write, done+err. rd_addr=3 reads 0. Without SUB_REGFILE_MOD_EN, any MOD gives done+err.

Source files
------------

// File: rtl/sub_regfile_pkg.sv
// Shared types and default sizing for the sub_regfile operand bank.
package sub_regfile_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_COPY = 2'd1,
    OP_SUB  = 2'd2,
    OP_MOD  = 2'd3
  } op_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MOD_LOOP = 1'b1
  } state_t;

endpackage

// File: rtl/sub_regfile_alu.sv
// Combinational subtract/compare shared by the SUB command and the MOD loop.
module sub_regfile_alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             ge
);

  assign diff = a - b;
  assign ge   = (a >= b);

endmodule

// File: rtl/sub_regfile.sv
// Operand register bank with LOAD/COPY/SUB and an iterative repeated-subtract MOD.
// The modulo opcode and its loop state exist only when SUB_REGFILE_MOD_EN is defined.
//
// state       | meaning
// ST_IDLE     | ready for a command; single-cycle ops complete here
// ST_MOD_LOOP | subtracting R[src] from R[dst] until R[dst] < R[src]
module sub_regfile
  import sub_regfile_pkg::*;
#(
  parameter int  WIDTH  = DEF_WIDTH,
  parameter int  NREGS  = DEF_NREGS,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              done,
  output logic              err,
  output logic              borrow
);

  localparam logic [ADDR_W:0] NREGS_A = (ADDR_W + 1)'(NREGS);

  logic [WIDTH-1:0]  regs [NREGS];
  state_t            state, state_nxt;
  op_t               op;
  logic              accept;
  logic              dst_ok, src_ok, legal;
  logic [ADDR_W-1:0] a_idx, b_idx;
  logic [WIDTH-1:0]  a_val, b_val, diff;
  logic              ge;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [WIDTH-1:0]  wr_data;
  logic              done_nxt, err_nxt, borrow_en;
  logic              done_q, err_q, borrow_q;

  assign op     = op_t'(cmd_op);
  assign accept = cmd_valid && cmd_ready;
  assign dst_ok = ({1'b0, cmd_dst} < NREGS_A);
  assign src_ok = ({1'b0, cmd_src} < NREGS_A);
  assign legal  = dst_ok && ((op == OP_LOAD) || src_ok);

`ifdef SUB_REGFILE_MOD_EN
  logic [ADDR_W-1:0] mod_dst, mod_src;
  logic              mod_latch;

  assign a_idx     = (state == ST_MOD_LOOP) ? mod_dst : cmd_dst;
  assign b_idx     = (state == ST_MOD_LOOP) ? mod_src : cmd_src;
  assign cmd_ready = (state == ST_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mod_dst <= '0;
      mod_src <= '0;
    end else if (mod_latch) begin
      mod_dst <= cmd_dst;
      mod_src <= cmd_src;
    end
  end
`else
  assign a_idx     = cmd_dst;
  assign b_idx     = cmd_src;
  assign cmd_ready = 1'b1;
`endif

  // Out-of-range indices read as zero rather than aliasing a real register.
  always_comb begin
    a_val   = '0;
    b_val   = '0;
    rd_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (a_idx == ADDR_W'(i))   a_val   = regs[i];
      if (b_idx == ADDR_W'(i))   b_val   = regs[i];
      if (rd_addr == ADDR_W'(i)) rd_data = regs[i];
    end
  end

  sub_regfile_alu #(.WIDTH(WIDTH)) u_alu (
    .a    (a_val),
    .b    (b_val),
    .diff (diff),
    .ge   (ge)
  );

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_idx    = a_idx;
    wr_data   = diff;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    borrow_en = 1'b0;
`ifdef SUB_REGFILE_MOD_EN
    mod_latch = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!legal) begin
            done_nxt = 1'b1;
            err_nxt  = 1'b1;
          end else begin
            case (op)
              OP_LOAD: begin
                wr_en    = 1'b1;
                wr_data  = cmd_data;
                done_nxt = 1'b1;
              end
              OP_COPY: begin
                wr_en    = 1'b1;
                wr_data  = b_val;
                done_nxt = 1'b1;
              end
              OP_SUB: begin
                wr_en     = 1'b1;
                wr_data   = diff;
                borrow_en = 1'b1;
                done_nxt  = 1'b1;
              end
              OP_MOD: begin
`ifdef SUB_REGFILE_MOD_EN
                if (b_val == '0) begin
                  done_nxt = 1'b1;
                  err_nxt  = 1'b1;
                end else begin
                  mod_latch = 1'b1;
                  state_nxt = ST_MOD_LOOP;
                end
`else
                done_nxt = 1'b1;
                err_nxt  = 1'b1;
`endif
              end
              default: ;
            endcase
          end
        end
      end
`ifdef SUB_REGFILE_MOD_EN
      // With dst==src the divisor itself reaches zero after one subtract,
      // so the nonzero test is what terminates that case.
      ST_MOD_LOOP: begin
        if (ge && (b_val != '0)) begin
          wr_en = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      borrow_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
      if (borrow_en) borrow_q <= ~ge;
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en && (wr_idx == ADDR_W'(i))) regs[i] <= wr_data;
      end
    end
  end

  assign done   = done_q;
  assign err    = err_q;
  assign borrow = borrow_q;

endmodule
